// File: rtl/instr_queue_pkg.sv
// instr_queue_pkg: shared defaults and field layout for the instruction queue
package instr_queue_pkg;
  localparam int IW_DEF = 16;
  localparam int OPW_DEF = 4;
  localparam int RW_DEF = 4;
  localparam int DEPTH_DEF = 4;
  localparam int SB_F = 0;
  localparam int SA_F = 1;
  localparam int DR_F = 2;
  localparam int OP_F = 3;
  function automatic int field_lo(input int rw, input int f);
    return f * rw;
  endfunction
endpackage

// File: rtl/iq_storage.sv
// iq_storage: DEPTH x IW register array, one write port, async read, no reset
module iq_storage #(
  parameter int IW = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk_main,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [IW-1:0]            wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [IW-1:0]            rdata
);
  logic [IW-1:0] mem [DEPTH];
  always_ff @(negedge clk_main)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/instr_queue.sv
// instr_queue: falling-edge instruction FIFO with head field decode
module instr_queue
  import instr_queue_pkg::*;
#(
  parameter int IW = IW_DEF,
  parameter int OPW = OPW_DEF,
  parameter int RW = RW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                       clk_main,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [IW-1:0]              in_ins,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OPW-1:0]             opcode,
  output logic [RW-1:0]              DR,
  output logic [RW-1:0]              SA,
  output logic [RW-1:0]              SB,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  if (IW != OPW + 3 * RW) begin : g_bad_width
    $error("instr_queue: IW must equal OPW + 3*RW");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("instr_queue: DEPTH must be a power of two >= 2");
  end
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [IW-1:0] head_raw, head;
  logic push, pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign in_ready = !full;
  assign out_valid = !empty;
  assign push = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(negedge clk_main or negedge reset_n)
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push != pop) count <= push ? count + 1'b1 : count - 1'b1;
    end
  iq_storage #(.IW(IW), .DEPTH(DEPTH)) u_storage (
    .clk_main (clk_main),
    .we       (push && !flush),
    .waddr    (wr_ptr),
    .wdata    (in_ins),
    .raddr    (rd_ptr),
    .rdata    (head_raw)
  );
  // Masking on empty keeps stale storage from ever reaching the fields.
  assign head = empty ? '0 : head_raw;
  assign opcode = head[field_lo(RW, OP_F) +: OPW];
  assign DR = head[field_lo(RW, DR_F) +: RW];
  assign SA = head[field_lo(RW, SA_F) +: RW];
  assign SB = head[field_lo(RW, SB_F) +: RW];
endmodule

// File: tb/tb_instr_queue.sv
// tb_instr_queue: directed stimulus with a scoreboard-driven pop monitor
module tb_instr_queue;
  logic clk_main = 1'b1;
  logic reset_n, flush, in_valid, out_ready;
  logic [15:0] in_ins;
  logic in_ready, out_valid, full, empty;
  logic [3:0] opcode, DR, SA, SB;
  logic [2:0] count;
  int tests = 0;
  int fails = 0;
  int mcount = 0;
  logic [15:0] exp_q[$];

  instr_queue dut (
    .clk_main  (clk_main),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ins    (in_ins),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .opcode    (opcode),
    .DR        (DR),
    .SA        (SA),
    .SB        (SB),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always #5 clk_main = ~clk_main;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Pops happen on the falling edge; sample the head mid-way through the high phase.
  always @(posedge clk_main) begin
    #3;
    if (reset_n && !flush && out_valid && out_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL pop_unexpected: got 0x%0h expected none", {opcode, DR, SA, SB});
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if ({opcode, DR, SA, SB} != e) begin
          fails++;
          $display("FAIL pop_word: got 0x%0h expected 0x%0h", {opcode, DR, SA, SB}, e);
        end
      end
    end
  end

  // Called just after a rising edge; applies inputs across the next falling edge.
  task automatic step(input logic v, input logic [15:0] w, input logic r, input logic f);
    logic acc, pp;
    in_valid = v;
    in_ins = w;
    out_ready = r;
    flush = f;
    acc = v && mcount < 4 && !f;
    pp = r && mcount > 0 && !f;
    if (f) begin
      exp_q.delete();
      mcount = 0;
    end else begin
      if (acc) exp_q.push_back(w);
      mcount = mcount + int'(acc) - int'(pp);
    end
    @(negedge clk_main);
    @(posedge clk_main);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    flush = 1'b0;
  endtask

  task automatic chk_count(input string name);
    chk(name, int'(count), mcount);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] ws[4];
    reset_n = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_ins = '0;
    repeat (2) @(posedge clk_main);
    #1;
    reset_n = 1'b1;
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_fields", int'({opcode, DR, SA, SB}), 0);

    step(1'b1, 16'h1234, 1'b0, 1'b0);
    chk("p1_out_valid", int'(out_valid), 1);
    chk("p1_opcode", int'(opcode), 1);
    chk("p1_dr", int'(DR), 2);
    chk("p1_sa", int'(SA), 3);
    chk("p1_sb", int'(SB), 4);
    chk("p1_count", int'(count), 1);
    step(1'b0, 16'h0, 1'b1, 1'b0);
    chk("p1_drained", int'(empty), 1);

    ws = '{16'hA000, 16'hB000, 16'hC000, 16'hD000};
    foreach (ws[i]) step(1'b1, ws[i], 1'b0, 1'b0);
    chk("fill_full", int'(full), 1);
    chk("fill_in_ready", int'(in_ready), 0);
    chk("fill_count", int'(count), 4);
    step(1'b1, 16'hE000, 1'b0, 1'b0);
    chk("reject_count", int'(count), 4);

    step(1'b1, 16'hF000, 1'b1, 1'b0);
    chk("full_pop_only", int'(count), 3);
    step(1'b1, 16'hF000, 1'b0, 1'b0);
    chk("refill_count", int'(count), 4);
    repeat (4) step(1'b0, 16'h0, 1'b1, 1'b0);
    chk("drain_empty", int'(empty), 1);

    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 16'(i), 1'b1, 1'b0);
      chk_count("alt_count");
      tests++;
      if (count > 3'd2) begin
        fails++;
        $display("FAIL alt_bound: got %0d expected <= 2", count);
      end
    end
    step(1'b0, 16'h0, 1'b1, 1'b0);
    chk("alt_empty", int'(empty), 1);

    step(1'b1, 16'h1111, 1'b0, 1'b0);
    step(1'b1, 16'h2222, 1'b0, 1'b0);
    step(1'b1, 16'h3333, 1'b0, 1'b0);
    chk("pre_flush_count", int'(count), 3);
    step(1'b1, 16'h4444, 1'b0, 1'b1);
    chk("flush_count", int'(count), 0);
    chk("flush_empty", int'(empty), 1);
    chk("flush_fields", int'({opcode, DR, SA, SB}), 0);
    step(1'b1, 16'h7777, 1'b0, 1'b0);
    chk("post_flush_head", int'({opcode, DR, SA, SB}), 16'h7777);
    step(1'b0, 16'h0, 1'b1, 1'b0);

    step(1'b1, 16'h9999, 1'b0, 1'b0);
    step(1'b1, 16'hAAAA, 1'b0, 1'b0);
    chk("pre_rst_count", int'(count), 2);
    reset_n = 1'b0;
    #1;
    chk("async_rst_empty", int'(empty), 1);
    chk("async_rst_out_valid", int'(out_valid), 0);
    chk("async_rst_count", int'(count), 0);
    reset_n = 1'b1;
    exp_q.delete();
    mcount = 0;
    step(1'b1, 16'h5678, 1'b0, 1'b0);
    chk("post_rst_opcode", int'(opcode), 5);
    chk("post_rst_count", int'(count), 1);
    step(1'b0, 16'h0, 1'b1, 1'b0);
    chk_count("final_count");
    chk("final_queue_left", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/instr_queue.md
INSTR_QUEUE -- requirements
Module: instr_queue

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
- IW, 16, instruction width.
- OPW, 4, opcode field width.
- RW, 4, width of each register field (DR, SA, SB).
- DEPTH, 4, queue entries; power of two, at least 2.
REQ-002 The module SHALL enforce IW == OPW + 3*RW at elaboration and fail on mismatch.
REQ-003 Ports SHALL be, as name, direction, width, meaning:
- clk_main, in, 1, single clock.
- reset_n, in, 1, asynchronous active-low reset.
- flush, in, 1, synchronous queue clear (branch or redirect).
- in_valid, in, 1, instruction offered.
- in_ins, in, IW, instruction word.
- in_ready, out, 1, queue accepts.
- out_valid, out, 1, head entry present.
- out_ready, in, 1, consumer takes the head.
- opcode, out, OPW, head field in_ins[IW-1 -: OPW].
- DR, out, RW, next field below opcode.
- SA, out, RW, next field below DR.
- SB, out, RW, low field, bits [RW-1:0].
- count, out, $clog2(DEPTH+1), occupancy.
- full, out, 1, count == DEPTH.
- empty, out, 1, count == 0.

Function
REQ-004 All state SHALL update on the falling edge of clk_main, matching codebase datapath timing.
REQ-005 A push SHALL occur on an edge where in_valid && in_ready; a pop SHALL occur on an edge where out_valid && out_ready.
REQ-006 in_ready SHALL equal !full, with no combinational path from out_ready; a full queue rejects pushes even when a pop occurs on the same edge.
REQ-007 out_valid SHALL equal !empty.
REQ-008 opcode, DR, SA and SB SHALL decode the head entry combinationally from storage, and SHALL be all-zero while empty.
REQ-009 Latency: a pushed word SHALL become visible at the head no earlier than the edge after its push; there is no input-to-output bypass.
REQ-010 On a simultaneous push and pop with count in 1..DEPTH-1, count SHALL remain unchanged and both pointers SHALL advance.
REQ-011 Read and write pointers SHALL wrap modulo DEPTH; order SHALL be strict FIFO across wrap-around.
REQ-012 A pop while empty is impossible (out_valid=0); a push while full is impossible (in_ready=0); storage SHALL be unchanged in both cases.
REQ-013 flush SHALL take priority over push and pop on the same edge; afterwards count=0, pointers=0, and the offered word is discarded.
REQ-014 full, empty and count SHALL be registered or derived only from registered state, and SHALL be glitch-free relative to inputs.

Reset
REQ-015 reset_n low SHALL asynchronously force pointers=0 and count=0, giving empty=1, full=0, out_valid=0, in_ready=1 and all fields zero.
REQ-016 Storage contents need not reset; outputs SHALL not expose stale data because of REQ-008.
REQ-017 Reset asserted mid-operation SHALL discard all entries; the first push after release SHALL appear at the head with count=1.

Structure
REQ-018 A shared package SHALL hold the parameter defaults (IW, OPW, RW, DEPTH) and the field-offset constants (opcode, DR, SA, SB low-bit positions).
REQ-019 Storage SHALL be a sub-module iq_storage: DEPTH x IW register array, one write port, one asynchronous read port, no reset.
REQ-020 Pointer and count control and field decode SHALL live in instr_queue.

Verification
REQ-021 The bench SHALL cover these directed scenarios with default parameters:
- Reset then push 0x1234 -> next edge: out_valid=1, opcode=1, DR=2, SA=3, SB=4, count=1.
- Push 0xA000, 0xB000, 0xC000, 0xD000 with out_ready=0 -> full=1, in_ready=0, count=4; offer 0xE000 -> rejected, count stays 4.
- Full queue, out_ready=1, in_valid=1 for one edge -> pop only, count=3; next edge push accepted, count=4.
- Ten alternating push/pop cycles, words 0x0001..0x000A -> words emerge in order across pointer wrap; count never exceeds 2.
- Count=3, flush=1 with in_valid=1 on the same edge -> count=0, empty=1, fields=0; offered word absent.
- Count=2, reset_n pulsed low between edges -> immediately empty=1, out_valid=0; after release, push 0x5678 -> head opcode=5, count=1.
